// File: rtl/line_slide_merge.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// line_slide_merge : compacts and merges three 3-tile lines, one per cycle.
// Rev 1.0
// ---------------------------------------------------------------------------
module line_slide_merge (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       dir_rev,
  input  logic [8:0] t0,
  input  logic [8:0] t1,
  input  logic [8:0] t2,
  output logic [8:0] c0,
  output logic [8:0] c1,
  output logic [8:0] c2,
  output logic       busy,
  output logic       done,
  output logic       changed,
  output logic [8:0] score_add,
  output logic       win
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_L0   = 2'd1;
  localparam logic [1:0] S_L1   = 2'd2;
  localparam logic [1:0] S_L2   = 2'd3;
  localparam logic [2:0] C_EXP_CAP = 3'd7;

  logic [1:0] r_state;
  logic [1:0] w_next;

  logic [8:0] r_t0, r_t1, r_t2;
  logic       r_dir;
  logic [8:0] r_res0, r_res1;
  logic [8:0] r_score_acc;
  logic       r_chg_acc, r_win_acc;
  logic [8:0] r_c0, r_c1, r_c2, r_score;
  logic       r_done, r_changed, r_win;

  logic [8:0] w_line, w_res, w_score;
  logic       w_chg, w_win;
  logic [2:0] w_p [3];
  logic [2:0] w_q [3];
  logic [2:0] w_r [3];
  logic [1:0] w_k;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_L0;
      S_L0:    w_next = S_L1;
      S_L1:    w_next = S_L2;
      S_L2:    w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != S_IDLE);
  end

  always_comb begin
    case (r_state)
      S_L1:    w_line = r_t1;
      S_L2:    w_line = r_t2;
      default: w_line = r_t0;
    endcase
  end

  // Work in slide order (toward index 0); reversal is undone when repacking.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_p[i] = r_dir ? w_line[3*(2-i) +: 3] : w_line[3*i +: 3];
      w_q[i] = 3'd0;
    end
    w_k = 2'd0;
    for (int i = 0; i < 3; i++) begin
      if (w_p[i] != 3'd0) begin
        case (w_k)
          2'd0:    w_q[0] = w_p[i];
          2'd1:    w_q[1] = w_p[i];
          default: w_q[2] = w_p[i];
        endcase
        w_k = w_k + 2'd1;
      end
    end

    w_r[0]  = w_q[0];
    w_r[1]  = w_q[1];
    w_r[2]  = w_q[2];
    w_score = 9'd0;
    w_win   = 1'b0;
    if (w_q[0] != 3'd0 && w_q[0] == w_q[1] && w_q[0] != C_EXP_CAP) begin
      w_r[0]  = w_q[0] + 3'd1;
      w_r[1]  = w_q[2];
      w_r[2]  = 3'd0;
      w_score = 9'd1 << w_r[0];
      w_win   = (w_r[0] == C_EXP_CAP);
    end else if (w_q[1] != 3'd0 && w_q[1] == w_q[2] && w_q[1] != C_EXP_CAP) begin
      w_r[1]  = w_q[1] + 3'd1;
      w_r[2]  = 3'd0;
      w_score = 9'd1 << w_r[1];
      w_win   = (w_r[1] == C_EXP_CAP);
    end

    w_res = 9'd0;
    for (int i = 0; i < 3; i++) begin
      if (r_dir) w_res[3*(2-i) +: 3] = w_r[i];
      else       w_res[3*i +: 3]     = w_r[i];
    end
    w_chg = (w_res != w_line);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_t0        <= 9'd0;
      r_t1        <= 9'd0;
      r_t2        <= 9'd0;
      r_dir       <= 1'b0;
      r_res0      <= 9'd0;
      r_res1      <= 9'd0;
      r_score_acc <= 9'd0;
      r_chg_acc   <= 1'b0;
      r_win_acc   <= 1'b0;
      r_c0        <= 9'd0;
      r_c1        <= 9'd0;
      r_c2        <= 9'd0;
      r_score     <= 9'd0;
      r_changed   <= 1'b0;
      r_win       <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_t0        <= t0;
            r_t1        <= t1;
            r_t2        <= t2;
            r_dir       <= dir_rev;
            r_score_acc <= 9'd0;
            r_chg_acc   <= 1'b0;
            r_win_acc   <= 1'b0;
          end
        end
        S_L0: begin
          r_res0      <= w_res;
          r_score_acc <= r_score_acc + w_score;
          r_chg_acc   <= r_chg_acc | w_chg;
          r_win_acc   <= r_win_acc | w_win;
        end
        S_L1: begin
          r_res1      <= w_res;
          r_score_acc <= r_score_acc + w_score;
          r_chg_acc   <= r_chg_acc | w_chg;
          r_win_acc   <= r_win_acc | w_win;
        end
        S_L2: begin
          r_c0      <= r_res0;
          r_c1      <= r_res1;
          r_c2      <= w_res;
          r_score   <= r_score_acc + w_score;
          r_changed <= r_chg_acc | w_chg;
          r_win     <= r_win_acc | w_win;
          r_done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign c0        = r_c0;
  assign c1        = r_c1;
  assign c2        = r_c2;
  assign score_add = r_score;
  assign changed   = r_changed;
  assign win       = r_win;
  assign done      = r_done;

endmodule
`default_nettype wire
